// File: rtl/regfile_port_ctrl.sv
// Register-bank port initiator: queues writes in a small FIFO, drains them onto we_RF/A3/WD3,
// then sequences operand reads via A1/A2 -> RD1/RD2. Address range checking: REGFILE_ADDR_CHECK_EN.
module regfile_port_ctrl #(
  parameter int DATA_W      = 26,
  parameter int ADDR_W      = 5,
  parameter int NUM_REGS    = 13,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd1,
  output logic [DATA_W-1:0] rsp_rd2,
  output logic              we_RF,
  output logic [ADDR_W-1:0] A1,
  output logic [ADDR_W-1:0] A2,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic              err_addr
);
  localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(WFIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WFIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE    = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_we_RF;
  logic [ADDR_W-1:0] r_A1;
  logic [ADDR_W-1:0] r_A2;
  logic [ADDR_W-1:0] r_A3;
  logic [DATA_W-1:0] r_WD3;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rd1;
  logic [DATA_W-1:0] r_rsp_rd2;
  logic              r_rd_bad;

  logic              w_wr_acc;
  logic              w_wr_bad;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_acc;
  logic              w_rd_bad;
  logic              w_stay_write;
  logic [PTR_W-1:0]  w_rptr_nxt;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_next_data;

  assign wr_ready   = (r_count != FULL_CNT);
  assign rd_ready   = (r_state == S_IDLE) && (r_count == '0);
  assign w_wr_acc   = wr_valid && wr_ready;
  assign w_push     = w_wr_acc && !w_wr_bad;
  assign w_pop      = (r_state == S_WRITE);
  assign w_rd_acc   = rd_valid && rd_ready;
  assign w_rptr_nxt = r_rptr + PTR_W'(1);

  // With only one entry left, a same-cycle push is the next head; forward it past the FIFO memory.
  assign w_stay_write = (r_count > ONE_CNT) || w_push;
  assign w_next_addr  = (r_count > ONE_CNT) ? r_fifo_addr[w_rptr_nxt] : wr_addr;
  assign w_next_data  = (r_count > ONE_CNT) ? r_fifo_data[w_rptr_nxt] : wr_data;

`ifdef REGFILE_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
  logic r_err;

  assign w_wr_bad = ({1'b0, wr_addr} >= NUM_REGS_C);
  assign w_rd_bad = ({1'b0, rd_addr1} >= NUM_REGS_C) || ({1'b0, rd_addr2} >= NUM_REGS_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_wr_acc && w_wr_bad) || (w_rd_acc && w_rd_bad);
    end
  end

  assign err_addr = r_err;
`else
  assign w_wr_bad = 1'b0;
  assign w_rd_bad = 1'b0;
  assign err_addr = 1'b0;
`endif

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer: bank-side outputs load on the edge that enters each state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_we_RF     <= 1'b0;
      r_A1        <= '0;
      r_A2        <= '0;
      r_A3        <= '0;
      r_WD3       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rd1   <= '0;
      r_rsp_rd2   <= '0;
      r_rd_bad    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state <= S_WRITE;
            r_we_RF <= 1'b1;
            r_A3    <= r_fifo_addr[r_rptr];
            r_WD3   <= r_fifo_data[r_rptr];
          end else if (rd_valid) begin
            r_state  <= S_RD_ISSUE;
            r_A1     <= rd_addr1;
            r_A2     <= rd_addr2;
            r_rd_bad <= w_rd_bad;
          end
        end
        S_WRITE: begin
          if (w_stay_write) begin
            r_A3  <= w_next_addr;
            r_WD3 <= w_next_data;
          end else begin
            r_state <= S_IDLE;
            r_we_RF <= 1'b0;
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rd1   <= r_rd_bad ? '0 : RD1;
          r_rsp_rd2   <= r_rd_bad ? '0 : RD2;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we_RF <= 1'b0;
        end
      endcase
    end
  end

  assign we_RF     = r_we_RF;
  assign A1        = r_A1;
  assign A2        = r_A2;
  assign A3        = r_A3;
  assign WD3       = r_WD3;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rd1   = r_rsp_rd1;
  assign rsp_rd2   = r_rsp_rd2;

endmodule
